// File: rtl/alu_uart_pkg.sv
// Shared definitions for the UART ALU host: opcodes, FSM states and the bit-time helper.
package alu_uart_pkg;

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_AND = 4'h2;
   localparam logic [3:0] OP_OR  = 4'h3;
   localparam logic [3:0] OP_XOR = 4'h4;
   localparam logic [3:0] OP_SHL = 4'h5;
   localparam logic [3:0] OP_SHR = 4'h6;
   localparam logic [3:0] OP_ROL = 4'h7;
   localparam logic [3:0] OP_ROR = 4'h8;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_TX_START = 4'd1,
      ST_TX_DATA  = 4'd2,
      ST_TX_STOP  = 4'd3,
      ST_RX_WAIT  = 4'd4,
      ST_RX_START = 4'd5,
      ST_RX_DATA  = 4'd6,
      ST_RX_STOP  = 4'd7,
      ST_RESP     = 4'd8
   } state_t;

   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable bit-period down-counter shared by the transmit and receive paths;
// mid_tick marks the bit centre after a load, end_tick the last cycle of the bit.
module uart_bit_timer #(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   output logic o_mid_tick,
   output logic o_end_tick
);
   localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] MID_VAL  = CNT_W'(CLKS_PER_BIT - CLKS_PER_BIT / 2);

   logic [CNT_W-1:0] r_cnt;

   // Count down from the load value and park at zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= {CNT_W{1'b0}};
      end else if (i_load) begin
         r_cnt <= LOAD_VAL;
      end else if (r_cnt != {CNT_W{1'b0}}) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign o_mid_tick = (r_cnt == MID_VAL);
   assign o_end_tick = (r_cnt == {CNT_W{1'b0}});

endmodule

// File: rtl/alu_uart_host.sv
// UART command initiator for the UART ALU: sends {op, A, B} as three 8N1 frames,
// then receives the one-byte result, flagging a response timeout or a bad stop bit.
module alu_uart_host
   import alu_uart_pkg::*;
#(
   parameter int CLK_FREQ     = 50_000_000,
   parameter int BAUD         = 9600,
   parameter int TIMEOUT_BITS = 40
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_op,
   input  logic [7:0] cmd_a,
   input  logic [7:0] cmd_b,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       rsp_timeout,
   output logic       rsp_frame_err,
   output logic       busy,
   output logic       tx,
   input  logic       rx
);
   localparam int CPB       = clks_per_bit(CLK_FREQ, BAUD);
   localparam int TO_CYCLES = TIMEOUT_BITS * CPB;
   // Extra headroom: the counter keeps running through RX_START glitch checks.
   localparam int TO_W      = $clog2(TO_CYCLES + CPB + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

   state_t          r_state;
   state_t          w_state_next;
   logic            w_tmr_load;
   logic            w_mid_tick;
   logic            w_end_tick;
   logic            w_to_expired;
   logic [23:0]     r_cmd;
   logic [1:0]      r_byte_idx;
   logic [2:0]      r_bit_idx;
   logic [7:0]      r_rx_shift;
   logic            r_rx_meta;
   logic            r_rx_sync;
   logic [TO_W-1:0] r_to_cnt;
   logic            r_tx;
   logic            r_rsp_valid;
   logic [7:0]      r_rsp_data;
   logic            r_rsp_timeout;
   logic            r_rsp_frame_err;

   uart_bit_timer #(.CLKS_PER_BIT(CPB)) u_bit_timer (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_tmr_load),
      .o_mid_tick (w_mid_tick),
      .o_end_tick (w_end_tick)
   );

   assign w_to_expired = (r_to_cnt >= TO_LAST);

   // Next-state and bit-timer reload decisions.
   always_comb begin
      w_state_next = r_state;
      w_tmr_load   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (cmd_valid) begin
               w_state_next = ST_TX_START;
               w_tmr_load   = 1'b1;
            end else begin
               w_state_next = ST_IDLE;
            end
         end
         ST_TX_START: begin
            if (w_end_tick) begin
               w_state_next = ST_TX_DATA;
               w_tmr_load   = 1'b1;
            end else begin
               w_state_next = r_state;
            end
         end
         ST_TX_DATA: begin
            if (w_end_tick) begin
               w_state_next = (r_bit_idx == 3'd7) ? ST_TX_STOP : ST_TX_DATA;
               w_tmr_load   = 1'b1;
            end else begin
               w_state_next = r_state;
            end
         end
         ST_TX_STOP: begin
            if (w_end_tick && (r_byte_idx == 2'd2)) begin
               w_state_next = ST_RX_WAIT;
            end else if (w_end_tick) begin
               w_state_next = ST_TX_START;
               w_tmr_load   = 1'b1;
            end else begin
               w_state_next = r_state;
            end
         end
         ST_RX_WAIT: begin
            if (!r_rx_sync) begin
               w_state_next = ST_RX_START;
               w_tmr_load   = 1'b1;
            end else if (w_to_expired) begin
               w_state_next = ST_RESP;
            end else begin
               w_state_next = r_state;
            end
         end
         ST_RX_START: begin
            if (w_mid_tick && r_rx_sync) begin
               w_state_next = ST_RX_WAIT;
            end else if (w_mid_tick) begin
               w_state_next = ST_RX_DATA;
               w_tmr_load   = 1'b1;
            end else begin
               w_state_next = r_state;
            end
         end
         ST_RX_DATA: begin
            if (w_end_tick) begin
               w_state_next = (r_bit_idx == 3'd7) ? ST_RX_STOP : ST_RX_DATA;
               w_tmr_load   = 1'b1;
            end else begin
               w_state_next = r_state;
            end
         end
         ST_RX_STOP: begin
            if (w_end_tick) begin
               w_state_next = ST_RESP;
            end else begin
               w_state_next = r_state;
            end
         end
         ST_RESP: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // State register, rx synchronizer, shift registers, timeout counter and outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state         <= ST_IDLE;
         r_cmd           <= 24'h000000;
         r_byte_idx      <= 2'd0;
         r_bit_idx       <= 3'd0;
         r_rx_shift      <= 8'h00;
         r_rx_meta       <= 1'b1;
         r_rx_sync       <= 1'b1;
         r_to_cnt        <= {TO_W{1'b0}};
         r_tx            <= 1'b1;
         r_rsp_valid     <= 1'b0;
         r_rsp_data      <= 8'h00;
         r_rsp_timeout   <= 1'b0;
         r_rsp_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_rx_meta   <= rx;
         r_rx_sync   <= r_rx_meta;
         r_rsp_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  r_cmd           <= {cmd_b, cmd_a, 4'b0000, cmd_op};
                  r_byte_idx      <= 2'd0;
                  r_tx            <= 1'b0;
                  r_rsp_timeout   <= 1'b0;
                  r_rsp_frame_err <= 1'b0;
               end
            end
            ST_TX_START: begin
               if (w_end_tick) begin
                  r_tx      <= r_cmd[0];
                  r_bit_idx <= 3'd0;
               end
            end
            ST_TX_DATA: begin
               if (w_end_tick) begin
                  r_cmd     <= {1'b0, r_cmd[23:1]};
                  r_bit_idx <= r_bit_idx + 3'd1;
                  r_tx      <= (r_bit_idx == 3'd7) ? 1'b1 : r_cmd[1];
               end
            end
            ST_TX_STOP: begin
               if (w_end_tick) begin
                  r_to_cnt <= {TO_W{1'b0}};
                  if (r_byte_idx != 2'd2) begin
                     r_tx       <= 1'b0;
                     r_byte_idx <= r_byte_idx + 2'd1;
                  end
               end
            end
            ST_RX_WAIT: begin
               r_to_cnt <= r_to_cnt + TO_W'(1);
               if (r_rx_sync && w_to_expired) begin
                  r_rsp_valid   <= 1'b1;
                  r_rsp_timeout <= 1'b1;
                  r_rsp_data    <= 8'h00;
               end
            end
            ST_RX_START: begin
               r_to_cnt <= r_to_cnt + TO_W'(1);
               if (w_mid_tick) begin
                  r_bit_idx <= 3'd0;
               end
            end
            ST_RX_DATA: begin
               if (w_end_tick) begin
                  r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                  r_bit_idx  <= r_bit_idx + 3'd1;
               end
            end
            ST_RX_STOP: begin
               if (w_end_tick) begin
                  r_rsp_valid     <= 1'b1;
                  r_rsp_data      <= r_rx_shift;
                  r_rsp_frame_err <= ~r_rx_sync;
               end
            end
            default: begin
               r_tx <= 1'b1;
            end
         endcase
      end
   end

   assign cmd_ready     = (r_state == ST_IDLE);
   assign busy          = (r_state != ST_IDLE);
   assign tx            = r_tx;
   assign rsp_valid     = r_rsp_valid;
   assign rsp_data      = r_rsp_data;
   assign rsp_timeout   = r_rsp_timeout;
   assign rsp_frame_err = r_rsp_frame_err;

endmodule

// File: tb/tb_alu_uart_host.sv
// Directed, table-driven bench for alu_uart_host with a scaled bit time (16 clocks per bit).
module tb_alu_uart_host;

   localparam int CLK_FREQ  = 160;
   localparam int BAUD      = 10;
   localparam int CPB       = 16;
   localparam int TO_BITS   = 40;
   localparam int RX_LIMIT  = 2000;

   typedef struct {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] rbyte;
      logic       rstop;
      logic       silent;
      int         glitch;
      int         delay;
      logic       hold;
      logic [7:0] edata;
      logic       eto;
      logic       efe;
      int         ej;
   } vec_t;

   logic       clk;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_op;
   logic [7:0] cmd_a;
   logic [7:0] cmd_b;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       rsp_timeout;
   logic       rsp_frame_err;
   logic       busy;
   logic       tx;
   logic       rx;

   int         n_checks;
   int         n_fail;
   logic [7:0] last_data;
   vec_t       tbl [6];

   alu_uart_host #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .TIMEOUT_BITS(TO_BITS)) dut (
      .clk           (clk),
      .rst           (rst),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_op        (cmd_op),
      .cmd_a         (cmd_a),
      .cmd_b         (cmd_b),
      .rsp_valid     (rsp_valid),
      .rsp_data      (rsp_data),
      .rsp_timeout   (rsp_timeout),
      .rsp_frame_err (rsp_frame_err),
      .busy          (busy),
      .tx            (tx),
      .rx            (rx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Present a command, then follow tx cycle by cycle against the ideal 30-bit waveform.
   task automatic do_tx(input vec_t v);
      logic [7:0] bytes [3];
      logic [7:0] dec [3];
      int         errs [3];
      int         bi;
      int         fb;
      int         off;
      logic       expb;
      bytes[0] = {4'b0000, v.op};
      bytes[1] = v.a;
      bytes[2] = v.b;
      for (int i = 0; i < 3; i++) begin
         errs[i] = 0;
         dec[i]  = 8'h00;
      end
      cmd_op    = v.op;
      cmd_a     = v.a;
      cmd_b     = v.b;
      cmd_valid = 1'b1;
      check("cmd_ready at accept", 32'(cmd_ready), 32'd1);
      for (int k = 0; k < 30 * CPB; k++) begin
         @(negedge clk);
         if (k == 0) begin
            if (!v.hold) cmd_valid = 1'b0;
            check("busy after accept", 32'(busy), 32'd1);
            check("rsp_data held", 32'(rsp_data), 32'(last_data));
            check("flags cleared on accept", 32'({rsp_timeout, rsp_frame_err}), 32'd0);
         end
         bi  = k / (10 * CPB);
         fb  = (k % (10 * CPB)) / CPB;
         off = k % CPB;
         if (fb == 0) expb = 1'b0;
         else if (fb == 9) expb = 1'b1;
         else expb = bytes[bi][fb-1];
         if (tx !== expb) errs[bi]++;
         if (fb >= 1 && fb <= 8 && off == CPB / 2) dec[bi][fb-1] = tx;
      end
      for (int i = 0; i < 3; i++) begin
         check($sformatf("tx byte %0d value", i), 32'(dec[i]), 32'(bytes[i]));
         check($sformatf("tx byte %0d bit timing errors", i), 32'(errs[i]), 32'd0);
      end
   endtask

   // Act as the ALU: drive rx from RX_WAIT entry (j = 0) and note the rsp_valid cycle.
   task automatic do_rx(input vec_t v, output int jv, output logic got);
      logic [9:0] frame;
      frame = {v.rstop, v.rbyte, 1'b0};
      got   = 1'b0;
      jv    = -1;
      for (int j = 0; j < RX_LIMIT; j++) begin
         @(negedge clk);
         if (rsp_valid) begin
            got = 1'b1;
            jv  = j;
            break;
         end
         if (v.silent) rx = 1'b1;
         else if (j < v.glitch) rx = 1'b0;
         else if (j >= v.delay && j < v.delay + 10 * CPB) rx = frame[(j - v.delay) / CPB];
         else rx = 1'b1;
      end
   endtask

   task automatic run_vec(input vec_t v);
      int   jv;
      logic got;
      do_tx(v);
      do_rx(v, jv, got);
      rx = 1'b1;
      check("rsp_valid seen", 32'(got), 32'd1);
      check("rsp_valid cycle", 32'(jv), 32'(v.ej));
      check("rsp_data", 32'(rsp_data), 32'(v.edata));
      check("rsp_timeout", 32'(rsp_timeout), 32'(v.eto));
      check("rsp_frame_err", 32'(rsp_frame_err), 32'(v.efe));
      last_data = v.edata;
      if (v.hold) begin
         check("cmd_ready low during rsp_valid", 32'(cmd_ready), 32'd0);
         @(negedge clk);
      end else begin
         cmd_valid = 1'b0;
         @(negedge clk);
         check("rsp_valid single cycle", 32'(rsp_valid), 32'd0);
         check("cmd_ready after response", 32'(cmd_ready), 32'd1);
         repeat (3) @(negedge clk);
      end
   endtask

   initial begin
      int n_rv;
      int n_low;
      n_checks  = 0;
      n_fail    = 0;
      last_data = 8'h00;
      rst       = 1'b0;
      rx        = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 4'h0;
      cmd_a     = 8'h00;
      cmd_b     = 8'h00;

      // op, a, b, responder byte, stop, silent, glitch, delay, hold, data, to, fe, rsp cycle
      tbl[0] = '{4'h0, 8'd25, 8'd17, 8'h2A, 1'b1, 1'b0, 0, 0, 1'b0, 8'd42, 1'b0, 1'b0, 155};
      tbl[1] = '{4'h7, 8'h81, 8'h01, 8'h03, 1'b1, 1'b0, 0, 0, 1'b1, 8'h03, 1'b0, 1'b0, 155};
      tbl[2] = '{4'h8, 8'h81, 8'h01, 8'hC0, 1'b1, 1'b0, 0, 0, 1'b0, 8'hC0, 1'b0, 1'b0, 155};
      tbl[3] = '{4'h1, 8'd60, 8'd20, 8'h00, 1'b1, 1'b1, 0, 0, 1'b0, 8'h00, 1'b1, 1'b0, 640};
      tbl[4] = '{4'h2, 8'h0F, 8'h09, 8'h09, 1'b0, 1'b0, 4, 20, 1'b0, 8'h09, 1'b0, 1'b1, 175};
      tbl[5] = '{4'hF, 8'hA5, 8'h3C, 8'hEE, 1'b1, 1'b0, 0, 5, 1'b0, 8'hEE, 1'b0, 1'b0, 160};

      repeat (3) @(negedge clk);
      check("reset tx", 32'(tx), 32'd1);
      check("reset cmd_ready", 32'(cmd_ready), 32'd1);
      check("reset busy", 32'(busy), 32'd0);
      check("reset rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset rsp_data", 32'(rsp_data), 32'd0);
      check("reset flags", 32'({rsp_timeout, rsp_frame_err}), 32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         run_vec(tbl[i]);
      end

      // Reset in the middle of byte 2 data (cmd_b = 0, so tx is low at that point).
      cmd_op    = 4'h0;
      cmd_a     = 8'h00;
      cmd_b     = 8'h00;
      cmd_valid = 1'b1;
      check("cmd_ready before reset test", 32'(cmd_ready), 32'd1);
      for (int k = 0; k <= 23 * CPB + CPB / 2; k++) begin
         @(negedge clk);
         if (k == 0) cmd_valid = 1'b0;
      end
      check("tx low in byte 2 data", 32'(tx), 32'd0);
      check("busy in byte 2 data", 32'(busy), 32'd1);
      rst = 1'b0;
      #1;
      check("tx high on async reset", 32'(tx), 32'd1);
      check("cmd_ready in reset", 32'(cmd_ready), 32'd1);
      repeat (2) @(negedge clk);
      rst   = 1'b1;
      n_rv  = 0;
      n_low = 0;
      for (int k = 0; k < 50 * CPB; k++) begin
         @(negedge clk);
         if (rsp_valid) n_rv++;
         if (!tx) n_low++;
      end
      check("no rsp_valid after abort", 32'(n_rv), 32'd0);
      check("tx idle after abort", 32'(n_low), 32'd0);
      check("cmd_ready after release", 32'(cmd_ready), 32'd1);
      last_data = 8'h00;
      run_vec(tbl[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
